// File: rtl/input_sequencer_if.sv
// Push-button in, entry-sequence strobes and state out, between the sequencer and the adder/display side.
interface input_sequencer_if;
    logic       button;
    logic       save_A;
    logic       save_B;
    logic       show_result;
    logic       abort;
    logic [1:0] state;

    modport master (
        input  button,
        output save_A, save_B, show_result, abort, state
    );

    modport slave (
        output button,
        input  save_A, save_B, show_result, abort, state
    );
endinterface

// File: rtl/input_sequencer.sv
// Debounces the raw push-button and steps the two-operand entry sequence,
// issuing single-cycle save_A / save_B / show_result / abort strobes.
module input_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250_000,
    parameter int unsigned TIMEOUT_CYCLES  = 250_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input_sequencer_if.master bus
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        CALC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    logic          sync1, sync2;
    logic          deb, deb_d;
    logic [CW-1:0] deb_cnt;
    logic          press_c;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          save_a_q, save_a_d;
    logic          save_b_q, save_b_d;
    logic          show_q, show_d;
    logic          abort_q, abort_d;
    logic          timeout_c;

    // Synchroniser and debounce: a new level must hold DEBOUNCE_CYCLES samples of sync2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= bus.button;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end

    assign press_c = deb & ~deb_d;

    // Next-state, idle timer and strobe decode; a press in WAIT_B beats a simultaneous timeout.
    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        save_a_d  = 1'b0;
        save_b_d  = 1'b0;
        show_d    = 1'b0;
        abort_d   = 1'b0;
        timeout_c = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
        case (state_q)
            WAIT_A: begin
                if (press_c) begin
                    state_d  = WAIT_B;
                    save_a_d = 1'b1;
                end
            end
            WAIT_B: begin
                if (press_c) begin
                    state_d  = CALC;
                    save_b_d = 1'b1;
                end else if (timeout_c) begin
                    state_d = WAIT_A;
                    abort_d = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CALC: begin
                state_d = SHOW;
                show_d  = 1'b1;
            end
            SHOW: begin
                if (press_c) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_A;
            timer_q  <= '0;
            save_a_q <= 1'b0;
            save_b_q <= 1'b0;
            show_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            save_a_q <= save_a_d;
            save_b_q <= save_b_d;
            show_q   <= show_d;
            abort_q  <= abort_d;
        end
    end

    assign bus.save_A      = save_a_q;
    assign bus.save_B      = save_b_q;
    assign bus.show_result = show_q;
    assign bus.abort       = abort_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_input_sequencer.sv
// Bench for input_sequencer: segment table, hand-timed corner sequences and a
// randomized run against a window-based behavioural model.
module tb_input_sequencer;
    localparam int unsigned DEB = 4;
    localparam int unsigned TO  = 100;

    logic clk = 1'b0;
    logic rst_n;

    input_sequencer_if bus_if ();

    input_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: debounced level flips once the last DEB synchronised samples all disagree with it.
    bit       m_s1, m_s2, m_deb, m_deb_d;
    bit       m_hist[$];
    int       m_state, m_idle;
    bit [5:0] m_out;

    // Sampled DUT outputs and a toy adder fed by the strobes.
    bit       o_a, o_b, o_r, o_ab;
    bit [1:0] o_st;
    int       cur_x, a_reg, b_reg, disp;

    typedef struct {
        bit btn;
        int n;
        int na, nb, nr, nab;
        int st;
        int x;
    } row_t;
    row_t rows[$];

    function automatic logic [5:0] dut_out();
        return {bus_if.save_A, bus_if.save_B, bus_if.show_result, bus_if.abort, bus_if.state};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_d = 0;
        m_hist.delete();
        m_state = 0; m_idle = 0; m_out = '0;
    endfunction

    function automatic void model_edge(input bit b);
        bit press;
        bit flip;
        press = m_deb && !m_deb_d;
        m_out[5:2] = '0;
        case (m_state)
            0: if (press) begin m_state = 1; m_idle = 0; m_out[5] = 1'b1; end
            1: begin
                if (press) begin
                    m_state = 2; m_out[4] = 1'b1;
                end else if (m_idle == int'(TO) - 1) begin
                    m_state = 0; m_out[2] = 1'b1;
                end else begin
                    m_idle++;
                end
            end
            2: begin m_state = 3; m_out[3] = 1'b1; end
            default: if (press) m_state = 0;
        endcase
        if (m_state != 1) m_idle = 0;
        m_out[1:0] = 2'(m_state);

        m_deb_d = m_deb;
        m_hist.push_back(m_s2);
        if (m_hist.size() > int'(DEB)) void'(m_hist.pop_front());
        flip = (m_hist.size() == int'(DEB));
        foreach (m_hist[i]) if (m_hist[i] == m_deb) flip = 1'b0;
        if (flip) begin
            m_deb = ~m_deb;
            m_hist.delete();
        end
        m_s2 = m_s1;
        m_s1 = b;
    endfunction

    // One clock: drive at negedge, advance model at posedge, sample and compare 1 time unit later.
    task automatic step(input bit b);
        @(negedge clk);
        bus_if.button = b;
        @(posedge clk);
        if (rst_n) model_edge(b);
        else model_reset();
        #1;
        {o_a, o_b, o_r, o_ab, o_st} = dut_out();
        check("cycle_vs_model", 32'(dut_out()), 32'(m_out));
        if (o_a) a_reg = cur_x;
        if (o_b) b_reg = cur_x;
        if (o_r) disp = a_reg + b_reg;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, cnt, other, b_at, r_at, ab_at, st99;
        bit lvl;

        rst_n = 1'b0;
        bus_if.button = 1'b0;
        cur_x = 0; a_reg = 0; b_reg = 0; disp = 0;
        model_reset();
        #1;
        check("reset_outputs", 32'(dut_out()), 32'd0);
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;

        // Clean press held 20 cycles: single save_A after edge DEB+3.
        cur_x = 9; first = -1; cnt = 0; other = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1);
            if (o_a) begin cnt++; if (first < 0) first = i; end
            if (o_b || o_r || o_ab) other++;
            if (i == 6) check("t1_state_before_press", 32'(o_st), 32'd0);
        end
        check("t1_save_A_edge", 32'(first), 32'(DEB + 3));
        check("t1_save_A_count", 32'(cnt), 32'd1);
        check("t1_no_other_strobe", 32'(other), 32'd0);
        check("t1_state", 32'(o_st), 32'd1);

        rows.push_back('{0, 10, 0, 0, 0, 0, 1, 8});
        rows.push_back('{1, 10, 0, 1, 1, 0, 3, 8});
        rows.push_back('{0, 10, 0, 0, 0, 0, 3, 8});
        rows.push_back('{1, 10, 0, 0, 0, 0, 0, 8});
        rows.push_back('{0, 10, 0, 0, 0, 0, 0, 8});
        rows.push_back('{1, 1,  0, 0, 0, 0, 0, 5});
        rows.push_back('{0, 6,  0, 0, 0, 0, 0, 5});
        rows.push_back('{1, 2,  0, 0, 0, 0, 0, 5});
        rows.push_back('{0, 6,  0, 0, 0, 0, 0, 5});
        rows.push_back('{1, 3,  0, 0, 0, 0, 0, 5});
        rows.push_back('{0, 6,  0, 0, 0, 0, 0, 5});
        rows.push_back('{1, 1,  0, 0, 0, 0, 0, 5});
        rows.push_back('{0, 1,  0, 0, 0, 0, 0, 5});
        rows.push_back('{1, 12, 1, 0, 0, 0, 1, 5});
        rows.push_back('{0, 10, 0, 0, 0, 0, 1, 5});

        foreach (rows[r]) begin
            int na, nb, nr, nab;
            na = 0; nb = 0; nr = 0; nab = 0; b_at = -1; r_at = -1;
            cur_x = rows[r].x;
            for (int i = 0; i < rows[r].n; i++) begin
                step(rows[r].btn);
                if (o_a) na++;
                if (o_b) begin nb++; b_at = i; end
                if (o_r) begin nr++; r_at = i; end
                if (o_ab) nab++;
            end
            check($sformatf("row%0d_save_A", r), 32'(na), 32'(rows[r].na));
            check($sformatf("row%0d_save_B", r), 32'(nb), 32'(rows[r].nb));
            check($sformatf("row%0d_show", r), 32'(nr), 32'(rows[r].nr));
            check($sformatf("row%0d_abort", r), 32'(nab), 32'(rows[r].nab));
            check($sformatf("row%0d_state", r), 32'(o_st), 32'(rows[r].st));
            if (rows[r].nb == 1 && rows[r].nr == 1)
                check($sformatf("row%0d_show_after_B", r), 32'(r_at - b_at), 32'd1);
        end
        check("t2_adder_display", 32'(disp), 32'd17);

        // Timeout: abort exactly TO cycles after entering WAIT_B.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1);
        check("t4_enter_wait_b", 32'(o_a), 32'd1);
        ab_at = -1; cnt = 0; st99 = -1;
        for (int i = 1; i <= 100; i++) begin
            step(1'b0);
            if (o_ab) begin cnt++; ab_at = i; end
            if (i == 99) st99 = int'(o_st);
        end
        check("t4_abort_at", 32'(ab_at), 32'(TO));
        check("t4_abort_count", 32'(cnt), 32'd1);
        check("t4_state_before_abort", 32'(st99), 32'd1);
        check("t4_state_after_abort", 32'(o_st), 32'd0);

        // Press landing on the last idle cycle wins over the timeout.
        for (int i = 0; i < 7; i++) step(1'b1);
        check("t4b_enter_wait_b", 32'(o_a), 32'd1);
        b_at = -1; cnt = 0;
        for (int i = 1; i <= 105; i++) begin
            step(i >= 94);
            if (o_b && b_at < 0) b_at = i;
            if (o_ab) cnt++;
        end
        check("t4b_save_B_at", 32'(b_at), 32'd100);
        check("t4b_no_abort", 32'(cnt), 32'd0);
        check("t4b_state", 32'(o_st), 32'd3);

        // Async reset mid-debounce in WAIT_B, then held button re-enters.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
        check("t6_in_wait_b", 32'(o_st), 32'd1);
        step(1'b1);
        step(1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_reset_immediate", 32'(dut_out()), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1);
        rst_n = 1'b1;
        first = -1; cnt = 0; other = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1);
            if (o_a) begin cnt++; if (first < 0) first = i; end
            if (o_b || o_r || o_ab) other++;
        end
        check("t6_save_A_edge", 32'(first), 32'(DEB + 3));
        check("t6_save_A_count", 32'(cnt), 32'd1);
        check("t6_no_other_strobe", 32'(other), 32'd0);

        // Randomized runs of button levels, occasional long idles and async resets.
        do_reset();
        lvl = 1'b0;
        for (int cyc = 0; cyc < 4000; ) begin
            int len;
            lvl = ~lvl;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(90, 130)) : int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                step(lvl);
                cyc++;
            end
            if ($urandom_range(0, 149) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_reset_immediate", 32'(dut_out()), 32'd0);
                step(lvl);
                step(lvl);
                rst_n = 1'b1;
                cyc += 2;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
